// File: rtl/m_exc_stage.sv
// M-stage address exception detector (AdEL/AdES) and the M->W exception pipeline register.
// Merges with earlier-stage codes and keeps a saturating count of exceptions delivered to W.
module m_exc_stage #(
  parameter logic [31:0]        DM_TOP        = 32'h0000_2fff,
  parameter int unsigned        NDEV          = 2,
  parameter logic [NDEV*32-1:0] DEV_BASE      = {32'h0000_7f10, 32'h0000_7f00},
  parameter int unsigned        DEV_RD_BYTES  = 12,
  parameter int unsigned        DEV_WR_BYTES  = 8,
  parameter bit                 DEV_WORD_ONLY = 1'b1,
  parameter bit                 PREV_FIRST    = 1'b1,
  parameter int unsigned        CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_m,
  input  logic [31:0]      addr,
  input  logic             addr_ovf,
  input  logic [4:0]       exccode_ml,
  input  logic [31:0]      pc_m,
  input  logic             bd_m,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       exccode_mr,
  output logic             exc_w,
  output logic [4:0]       exccode_w,
  output logic [31:0]      epc_w,
  output logic             bd_w,
  output logic [31:0]      badvaddr_w,
  output logic [CNT_W-1:0] exc_cnt
);

  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpSw  = 6'h2b;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSb  = 6'h28;

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  localparam logic [32:0] RdSpan = 33'(DEV_RD_BYTES) - 33'd1;
  localparam logic [32:0] WrSpan = 33'(DEV_WR_BYTES) - 33'd1;

  logic [5:0] op;
  logic       is_load, is_store, is_word, is_half;
  logic       rd_hit, wr_hit;
  logic       misalign, ld_fault, st_fault;
  logic [4:0] mfault;
  logic       sel_m;
  logic [32:0] addr33;

  logic unused_instr;
  assign unused_instr = ^instr_m[25:0];

  assign op     = instr_m[31:26];
  assign addr33 = {1'b0, addr};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    case (op)
      OpLw:         begin is_load  = 1'b1; is_word = 1'b1; end
      OpLh, OpLhu:  begin is_load  = 1'b1; is_half = 1'b1; end
      OpLb, OpLbu:  is_load  = 1'b1;
      OpSw:         begin is_store = 1'b1; is_word = 1'b1; end
      OpSh:         begin is_store = 1'b1; is_half = 1'b1; end
      OpSb:         is_store = 1'b1;
      default:      ;
    endcase
  end

  // 33-bit compares so a window ending at the top of the address space cannot wrap.
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if ((addr33 >= {1'b0, DEV_BASE[32*i +: 32]}) &&
          (addr33 <= {1'b0, DEV_BASE[32*i +: 32]} + RdSpan)) begin
        rd_hit = 1'b1;
      end
      if ((addr33 >= {1'b0, DEV_BASE[32*i +: 32]}) &&
          (addr33 <= {1'b0, DEV_BASE[32*i +: 32]} + WrSpan)) begin
        wr_hit = 1'b1;
      end
    end
  end

  assign misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);

  assign ld_fault = is_load && (misalign || addr_ovf || ((addr > DM_TOP) && !rd_hit) ||
                                (DEV_WORD_ONLY && !is_word && rd_hit));
  assign st_fault = is_store && (misalign || addr_ovf || ((addr > DM_TOP) && !wr_hit) ||
                                 (DEV_WORD_ONLY && !is_word && wr_hit));

  always_comb begin
    mfault = 5'd0;
    if (ld_fault) begin
      mfault = ExcAdEL;
    end else if (st_fault) begin
      mfault = ExcAdES;
    end
  end

  // sel_m marks that the merged code came from this stage, which is what qualifies BadVAddr.
  always_comb begin
    if (PREV_FIRST) begin
      sel_m = (exccode_ml == 5'd0) && (mfault != 5'd0);
    end else begin
      sel_m = (mfault != 5'd0);
    end
    exccode_mr = sel_m ? mfault : exccode_ml;
  end

  logic             exc_q, exc_d;
  logic [4:0]       code_q, code_d;
  logic [31:0]      epc_q, epc_d;
  logic             bd_q, bd_d;
  logic [31:0]      bva_q, bva_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_en;

  assign load_en = !flush && !stall;

  always_comb begin
    exc_d  = exc_q;
    code_d = code_q;
    epc_d  = epc_q;
    bd_d   = bd_q;
    bva_d  = bva_q;
    cnt_d  = cnt_q;
    if (flush) begin
      exc_d  = 1'b0;
      code_d = 5'd0;
      epc_d  = 32'd0;
      bd_d   = 1'b0;
      bva_d  = 32'd0;
    end else if (!stall) begin
      exc_d  = (exccode_mr != 5'd0);
      code_d = exccode_mr;
      epc_d  = pc_m;
      bd_d   = bd_m;
      bva_d  = sel_m ? addr : 32'd0;
    end
    if (load_en && (exccode_mr != 5'd0) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_q  <= 1'b0;
      code_q <= 5'd0;
      epc_q  <= 32'd0;
      bd_q   <= 1'b0;
      bva_q  <= 32'd0;
      cnt_q  <= '0;
    end else begin
      exc_q  <= exc_d;
      code_q <= code_d;
      epc_q  <= epc_d;
      bd_q   <= bd_d;
      bva_q  <= bva_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exc_w      = exc_q;
  assign exccode_w  = code_q;
  assign epc_w      = epc_q;
  assign bd_w       = bd_q;
  assign badvaddr_w = bva_q;
  assign exc_cnt    = cnt_q;

endmodule

// File: tb/tb_m_exc_stage.sv
// Self-checking bench for m_exc_stage: directed scenarios plus randomized traffic checked
// against a behavioural model; a second instance covers PREV_FIRST=0 and a 2-bit counter.
module tb_m_exc_stage;

  localparam logic [31:0] DM_TOP = 32'h0000_2fff;

  logic        clk, reset;
  logic [31:0] instr_m, addr, pc_m;
  logic        addr_ovf, bd_m, stall, flush;
  logic [4:0]  exccode_ml;

  logic [4:0]  exccode_mr, exccode_w, exccode_mr2, exccode_w2;
  logic        exc_w, bd_w, exc_w2, bd_w2;
  logic [31:0] epc_w, badvaddr_w, epc_w2, badvaddr_w2;
  logic [15:0] exc_cnt;
  logic [1:0]  exc_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  m_exc_stage dut (
    .clk(clk), .reset(reset), .instr_m(instr_m), .addr(addr), .addr_ovf(addr_ovf),
    .exccode_ml(exccode_ml), .pc_m(pc_m), .bd_m(bd_m), .stall(stall), .flush(flush),
    .exccode_mr(exccode_mr), .exc_w(exc_w), .exccode_w(exccode_w), .epc_w(epc_w),
    .bd_w(bd_w), .badvaddr_w(badvaddr_w), .exc_cnt(exc_cnt)
  );

  m_exc_stage #(.PREV_FIRST(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .instr_m(instr_m), .addr(addr), .addr_ovf(addr_ovf),
    .exccode_ml(exccode_ml), .pc_m(pc_m), .bd_m(bd_m), .stall(stall), .flush(flush),
    .exccode_mr(exccode_mr2), .exc_w(exc_w2), .exccode_w(exccode_w2), .epc_w(epc_w2),
    .bd_w(bd_w2), .badvaddr_w(badvaddr_w2), .exc_cnt(exc_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural reference: classify by access size and address map.
  function automatic logic [4:0] ref_fault(input logic [31:0] ins, input logic [31:0] a,
                                           input logic ovf);
    longint ua, lim;
    longint bases[2];
    int     size;
    bit     ld, st, in_dev, bad;
    ld = 0; st = 0; size = 0; in_dev = 0;
    bases[0] = 64'h7f00;
    bases[1] = 64'h7f10;
    case (ins[31:26])
      6'h23:        begin ld = 1; size = 4; end
      6'h21, 6'h25: begin ld = 1; size = 2; end
      6'h20, 6'h24: begin ld = 1; size = 1; end
      6'h2b:        begin st = 1; size = 4; end
      6'h29:        begin st = 1; size = 2; end
      6'h28:        begin st = 1; size = 1; end
      default:      return 5'd0;
    endcase
    ua  = longint'({32'h0, a});
    lim = ld ? 12 : 8;
    for (int i = 0; i < 2; i++) if (ua >= bases[i] && ua < bases[i] + lim) in_dev = 1;
    bad = ovf || (ua % size != 0) || (ua > longint'({32'h0, DM_TOP}) && !in_dev) ||
          (in_dev && size != 4);
    return bad ? (ld ? 5'd4 : 5'd5) : 5'd0;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic ovf,
                       input logic [4:0] ml, input logic st, input logic fl);
    instr_m    = {op, 26'(($urandom))};
    addr       = a;
    addr_ovf   = ovf;
    exccode_ml = ml;
    stall      = st;
    flush      = fl;
    pc_m       = $urandom;
    bd_m       = 1'($urandom_range(0, 1));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(6'h00, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3;
    n_checks++;
    if ({exc_w, exccode_w, epc_w, bd_w, badvaddr_w, exc_cnt} !== '0) begin
      n_errors++; $display("FAIL reset_state got exc=%0d code=%0d cnt=%0d want 0", exc_w, exccode_w, exc_cnt);
    end
    n_checks++;
    if ({exc_w2, exccode_w2, epc_w2, bd_w2, badvaddr_w2, exc_cnt2} !== '0) begin
      n_errors++; $display("FAIL reset_state2 got exc=%0d code=%0d want 0", exc_w2, exccode_w2);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_misaligned_lw;
    logic [31:0] pc_exp;
    reset_pulse();
    drive(6'h23, 32'h0000_1002, 1'b0, 5'd0, 1'b0, 1'b0);
    pc_exp = pc_m;
    #1;
    n_checks++;
    if (exccode_mr !== 5'd4) begin n_errors++; $display("FAIL lw_mr got %0d want 4", exccode_mr); end
    tick();
    n_checks++;
    if ({exc_w, exccode_w, badvaddr_w, exc_cnt} !== {1'b1, 5'd4, 32'h1002, 16'd1}) begin
      n_errors++;
      $display("FAIL lw_w got exc=%0d code=%0d bva=%h cnt=%0d want 1 4 1002 1", exc_w, exccode_w, badvaddr_w, exc_cnt);
    end
    n_checks++;
    if (epc_w !== pc_exp) begin n_errors++; $display("FAIL lw_epc got %h want %h", epc_w, pc_exp); end
  endtask

  task automatic test_dev_windows;
    drive(6'h2b, 32'h7f08, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd5) begin n_errors++; $display("FAIL sw_7f08 got %0d want 5", exccode_mr); end
    drive(6'h2b, 32'h7f14, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd0) begin n_errors++; $display("FAIL sw_7f14 got %0d want 0", exccode_mr); end
    drive(6'h23, 32'h7f08, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd0) begin n_errors++; $display("FAIL lw_7f08 got %0d want 0", exccode_mr); end
    drive(6'h23, 32'h7f0c, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd4) begin n_errors++; $display("FAIL lw_7f0c got %0d want 4", exccode_mr); end
  endtask

  task automatic test_subword;
    drive(6'h28, 32'h7f00, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd5) begin n_errors++; $display("FAIL sb_dev got %0d want 5", exccode_mr); end
    drive(6'h28, 32'h2fff, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd0) begin n_errors++; $display("FAIL sb_2fff got %0d want 0", exccode_mr); end
    drive(6'h24, 32'h3000, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd4) begin n_errors++; $display("FAIL lbu_3000 got %0d want 4", exccode_mr); end
    drive(6'h08, 32'h3001, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd0) begin n_errors++; $display("FAIL nonmem got %0d want 0", exccode_mr); end
  endtask

  task automatic test_merge;
    drive(6'h23, 32'h3, 1'b0, 5'd10, 1'b0, 1'b0); #1;
    n_checks++;
    if ({exccode_mr, exccode_mr2} !== {5'd10, 5'd4}) begin
      n_errors++; $display("FAIL merge_mr got %0d/%0d want 10/4", exccode_mr, exccode_mr2);
    end
    tick();
    n_checks++;
    if ({exccode_w, badvaddr_w} !== {5'd10, 32'h0}) begin
      n_errors++; $display("FAIL merge_prev got code=%0d bva=%h want 10 0", exccode_w, badvaddr_w);
    end
    n_checks++;
    if ({exccode_w2, badvaddr_w2} !== {5'd4, 32'h3}) begin
      n_errors++; $display("FAIL merge_m got code=%0d bva=%h want 4 3", exccode_w2, badvaddr_w2);
    end
  endtask

  task automatic test_stall_flush;
    logic [31:0] pc_exp;
    reset_pulse();
    drive(6'h23, 32'h1001, 1'b0, 5'd0, 1'b0, 1'b0);
    pc_exp = pc_m;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(6'h2b, 32'h100, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if ({exc_w, exccode_w, epc_w, badvaddr_w, exc_cnt} !== {1'b1, 5'd4, pc_exp, 32'h1001, 16'd1}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d] got exc=%0d code=%0d epc=%h bva=%h cnt=%0d", i, exc_w, exccode_w, epc_w, badvaddr_w, exc_cnt);
      end
    end
    drive(6'h23, 32'h1001, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if ({exc_w, exccode_w, epc_w, bd_w, badvaddr_w, exc_cnt} !== {1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'd1}) begin
      n_errors++; $display("FAIL flush_stall got exc=%0d code=%0d cnt=%0d want 0 0 1", exc_w, exccode_w, exc_cnt);
    end
  endtask

  task automatic test_ovf;
    drive(6'h2b, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    n_checks++;
    if (exccode_mr !== 5'd5) begin n_errors++; $display("FAIL ovf_sw got %0d want 5", exccode_mr); end
  endtask

  task automatic test_saturation;
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      drive(6'h23, 32'h1002, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (exc_cnt2 !== 2'((i + 1 > 3) ? 3 : i + 1) || exc_cnt !== 16'(i + 1)) begin
        n_errors++; $display("FAIL sat[%0d] got cnt2=%0d cnt=%0d want %0d %0d", i, exc_cnt2, exc_cnt, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(6'h23, 32'h1002, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({exc_w, exccode_w, epc_w, bd_w, badvaddr_w, exc_cnt, exc_cnt2} !== '0) begin
      n_errors++; $display("FAIL async_reset got exc=%0d code=%0d cnt=%0d want 0", exc_w, exccode_w, exc_cnt);
    end
    #2;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({exc_w, exccode_w, exc_cnt} !== {1'b1, 5'd4, 16'd1}) begin
      n_errors++; $display("FAIL reset_release got exc=%0d code=%0d cnt=%0d want 1 4 1", exc_w, exccode_w, exc_cnt);
    end
  endtask

  task automatic test_random;
    logic [5:0]  ops[11];
    logic [5:0]  op;
    logic [31:0] a;
    logic [4:0]  mf, ml, e_mr, e_mr2;
    logic        e_exc, e_bd, e_exc2;
    logic [4:0]  e_code, e_code2;
    logic [31:0] e_epc, e_bva, e_bva2;
    int          e_cnt, e_cnt2;
    ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28, 6'h00, 6'h0f, 6'h08};
    reset_pulse();
    {e_exc, e_code, e_epc, e_bd, e_bva, e_exc2, e_code2, e_bva2} = '0;
    e_cnt = 0; e_cnt2 = 0;
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h3010);
        1:       a = 32'h7ef8 + $urandom_range(0, 32'h30);
        2:       a = $urandom;
        default: a = 32'h2ff8 + $urandom_range(0, 16);
      endcase
      ml = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      drive(op, a, ($urandom_range(0, 15) == 0), ml, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0));
      mf    = ref_fault(instr_m, addr, addr_ovf);
      e_mr  = (ml != 0) ? ml : mf;
      e_mr2 = (mf != 0) ? mf : ml;
      #1;
      n_checks++;
      if ({exccode_mr, exccode_mr2} !== {e_mr, e_mr2}) begin
        n_errors++;
        $display("FAIL rnd_mr[%0d] op=%h a=%h got %0d/%0d want %0d/%0d", n, op, a, exccode_mr, exccode_mr2, e_mr, e_mr2);
      end
      if (flush) begin
        {e_exc, e_code, e_epc, e_bd, e_bva, e_exc2, e_code2, e_bva2} = '0;
      end else if (!stall) begin
        e_exc = (e_mr != 0); e_code = e_mr; e_epc = pc_m; e_bd = bd_m;
        e_bva = (ml == 0 && mf != 0) ? a : 32'h0;
        e_exc2 = (e_mr2 != 0); e_code2 = e_mr2;
        e_bva2 = (mf != 0) ? a : 32'h0;
        if (e_mr != 0 && e_cnt < 65535) e_cnt++;
        if (e_mr2 != 0 && e_cnt2 < 3) e_cnt2++;
      end
      tick();
      n_checks++;
      if ({exc_w, exccode_w, epc_w, bd_w, badvaddr_w, exc_cnt} !==
          {e_exc, e_code, e_epc, e_bd, e_bva, 16'(e_cnt)}) begin
        n_errors++;
        $display("FAIL rnd_w[%0d] got exc=%0d code=%0d epc=%h bd=%0d bva=%h cnt=%0d want %0d %0d %h %0d %h %0d",
                 n, exc_w, exccode_w, epc_w, bd_w, badvaddr_w, exc_cnt, e_exc, e_code, e_epc, e_bd, e_bva, e_cnt);
      end
      n_checks++;
      if ({exc_w2, exccode_w2, badvaddr_w2, exc_cnt2} !== {e_exc2, e_code2, e_bva2, 2'(e_cnt2)}) begin
        n_errors++;
        $display("FAIL rnd_w2[%0d] got exc=%0d code=%0d bva=%h cnt=%0d want %0d %0d %h %0d",
                 n, exc_w2, exccode_w2, badvaddr_w2, exc_cnt2, e_exc2, e_code2, e_bva2, e_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_misaligned_lw();
    test_dev_windows();
    test_subword();
    test_merge();
    test_stall_flush();
    test_ovf();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
